// File: rtl/serial_deserializer_if.sv
// ---------------------------------------------------------------------------
// serial_deserializer_if
// Bundles the serial receive inputs and the parallel word output of
// serial_deserializer. The clock and reset are plain module ports.
//   master : the link side and the word consumer (drives EN/RL/start/serial,
//            ready and clr_ovr; observes the word and status flags)
//   slave  : the deserializer
// Signals:
//   EN, RL, start, serial : bit-valid, bit order, frame marker, serial data
//   ready, clr_ovr        : consumer accept, overrun clear
//   data_out, valid       : assembled word and its valid flag
//   busy, overrun         : frame in progress, sticky overrun
//   parity_err            : parity result of the last accepted word
// ---------------------------------------------------------------------------
interface serial_deserializer_if #(
   parameter int unsigned n = 8
);
   logic         EN;
   logic         RL;
   logic         start;
   logic         serial;
   logic         ready;
   logic         clr_ovr;
   logic [n-1:0] data_out;
   logic         valid;
   logic         busy;
   logic         overrun;
   logic         parity_err;

   modport master (
      output EN, RL, start, serial, ready, clr_ovr,
      input  data_out, valid, busy, overrun, parity_err
   );

   modport slave (
      input  EN, RL, start, serial, ready, clr_ovr,
      output data_out, valid, busy, overrun, parity_err
   );
endinterface

// File: rtl/serial_deserializer.sv
// ---------------------------------------------------------------------------
// serial_deserializer
// Serial-to-parallel receiver. A frame begins with a bit qualified by
// EN && start and carries n data bits, MSB-first (RL=0) or LSB-first (RL=1),
// the order being latched at frame start. A separate shift register lets
// the next frame arrive while the previous word is held on data_out.
// Completed words are offered on valid/ready; a completion while a word is
// still unconsumed drops the new word and sets the sticky overrun flag.
//
// Optional feature, macro SERIAL_DESERIALIZER_PARITY_EN:
//   each frame carries one extra odd-parity bit after the data bits, handled
//   in state PAR; parity_err reports the result of the last accepted word.
//   Without the macro, frames are n bits and parity_err is tied to 0.
//
// Ports:
//   clock  : bit clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : serial_deserializer_if.slave (see interface header)
// ---------------------------------------------------------------------------
module serial_deserializer #(
   parameter int unsigned n = 8
) (
   input  logic                  clock,
   input  logic                  resetn,
   serial_deserializer_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(n + 1);

`ifdef SERIAL_DESERIALIZER_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
   typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

   state_t             state_q, state_d;
   logic [n-1:0]       sr_q, sr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               dir_q, dir_d;
   logic [n-1:0]       data_q, data_d;
   logic               valid_q, valid_d;
   logic               ovr_q, ovr_d;
   logic               busy_q, busy_d;
   logic               done_c;
   logic [n-1:0]       word_c;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
   logic               perr_q, perr_d;
   logic               perr_c;
`endif

   // Shift one bit in; lsb_first places the first bit of a frame in the LSB.
   function automatic logic [n-1:0] shift_in(input logic [n-1:0] cur,
                                              input logic d,
                                              input logic lsb_first);
      return lsb_first ? {d, cur[n-1:1]} : {cur[n-2:0], d};
   endfunction

   // Next-state: framing, word completion and the output handshake.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      done_c  = 1'b0;
      word_c  = sr_q;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
      perr_d  = perr_q;
      perr_c  = 1'b0;
`endif

      // start always wins: a partial frame is silently discarded.
      if (bus.EN && bus.start) begin
         dir_d   = bus.RL;
         sr_d    = shift_in(sr_q, bus.serial, bus.RL);
         cnt_d   = CNT_W'(1);
         state_d = SHIFT;
      end else if (bus.EN) begin
         case (state_q)
            SHIFT: begin
               sr_d  = shift_in(sr_q, bus.serial, dir_q);
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(n - 1)) begin
`ifdef SERIAL_DESERIALIZER_PARITY_EN
                  state_d = PAR;
`else
                  done_c  = 1'b1;
                  word_c  = sr_d;
                  state_d = IDLE;
                  cnt_d   = '0;
`endif
               end
            end
`ifdef SERIAL_DESERIALIZER_PARITY_EN
            PAR: begin
               // Odd parity: data bits plus parity bit must XOR to 1.
               done_c  = 1'b1;
               word_c  = sr_q;
               perr_c  = ~((^sr_q) ^ bus.serial);
               state_d = IDLE;
               cnt_d   = '0;
            end
`endif
            default: ;
         endcase
      end

      // Clear first so a same-cycle overrun set takes priority.
      if (bus.clr_ovr) ovr_d = 1'b0;

      if (done_c) begin
         if (!valid_q || bus.ready) begin
            data_d  = word_c;
            valid_d = 1'b1;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
            perr_d  = perr_c;
`endif
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && bus.ready) begin
         valid_d = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         busy_q  <= 1'b0;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         busy_q  <= busy_d;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   assign bus.data_out = data_q;
   assign bus.valid    = valid_q;
   assign bus.busy     = busy_q;
   assign bus.overrun  = ovr_q;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
   assign bus.parity_err = perr_q;
`else
   assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// ---------------------------------------------------------------------------
// tb_serial_deserializer
// Directed bench for serial_deserializer (n=8). Inputs change on the falling
// edge, outputs are checked on the following falling edge. Expected words are
// queued when a frame is sent and popped when the word is checked.
// Honors SERIAL_DESERIALIZER_PARITY_EN when compiled with it.
// ---------------------------------------------------------------------------
module tb_serial_deserializer;

   localparam int unsigned N = 8;

   logic clock;
   logic resetn;
   int   n_checks;
   int   n_fail;
   logic [N-1:0] exp_q[$];
   logic [N-1:0] exp_w;

   serial_deserializer_if #(.n(N)) bus ();

   serial_deserializer #(.n(N)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Drive one cycle of inputs; returns on the next falling edge.
   task automatic drive(input logic en, input logic st, input logic sb);
      bus.EN     = en;
      bus.start  = st;
      bus.serial = sb;
      @(negedge clock);
   endtask

   // Send one frame. toggle inserts an EN-low cycle (with wrong data) before
   // every bit after the first. chk verifies busy/valid along the way.
   task automatic send_frame(input logic [N-1:0] w, input logic rl, input logic par,
                             input logic toggle, input logic chk);
      logic b;
      bus.RL = rl;
      for (int i = 0; i < int'(N); i++) begin
         b = rl ? w[i] : w[N-1-i];
         if (toggle && i > 0) begin
            drive(1'b0, 1'b0, ~b);
            if (chk) check("busy_hold", 32'(bus.busy), 32'd1);
         end
         drive(1'b1, (i == 0), b);
         if (chk && i < int'(N) - 1) begin
            check("busy_mid", 32'(bus.busy), 32'd1);
            check("valid_mid", 32'(bus.valid), 32'd0);
         end
      end
`ifdef SERIAL_DESERIALIZER_PARITY_EN
      if (chk) begin
         check("busy_par", 32'(bus.busy), 32'd1);
         check("valid_par", 32'(bus.valid), 32'd0);
      end
      if (toggle) drive(1'b0, 1'b0, ~par);
      drive(1'b1, 1'b0, par);
`else
      b = par;
`endif
      bus.EN = 1'b0;
      bus.start = 1'b0;
   endtask

   // Pop the next expected word and check it is presented.
   task automatic check_word(input string tag);
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL %s observed=empty_queue expected=word", tag);
      end else begin
         exp_w = exp_q.pop_front();
         check(tag, 32'(bus.data_out), 32'(exp_w));
         check({tag, "_valid"}, 32'(bus.valid), 32'd1);
      end
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      resetn     = 1'b0;
      bus.EN     = 1'b0;
      bus.RL     = 1'b0;
      bus.start  = 1'b0;
      bus.serial = 1'b0;
      bus.ready  = 1'b1;
      bus.clr_ovr = 1'b0;
      repeat (2) @(negedge clock);
      check("reset_outputs",
            32'({bus.data_out, bus.valid, bus.busy, bus.overrun, bus.parity_err}), 32'd0);
      resetn = 1'b1;
      @(negedge clock);

      // MSB-first, EN continuous
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b0, ~^8'hA5, 1'b0, 1'b1);
      check_word("msb_first");
      check("busy_end", 32'(bus.busy), 32'd0);
      drive(1'b0, 1'b0, 1'b0);
      check("consume", 32'(bus.valid), 32'd0);

      // LSB-first, EN toggling
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, ~^8'hA5, 1'b1, 1'b1);
      check_word("lsb_first_toggle");
      drive(1'b0, 1'b0, 1'b0);

      // Back-to-back frames, ready high
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b0, ~^8'h5A, 1'b0, 1'b0);
      check_word("b2b_first");
      exp_q.push_back(8'h0F);
      send_frame(8'h0F, 1'b1, ~^8'h0F, 1'b0, 1'b0);
      check_word("b2b_second");
      check("b2b_overrun", 32'(bus.overrun), 32'd0);
      drive(1'b0, 1'b0, 1'b0);

      // Overrun with ready low
      bus.ready = 1'b0;
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b0, ~^8'h3C, 1'b0, 1'b0);
      check("ovr_first", 32'(bus.data_out), 32'h3C);
      send_frame(8'hC3, 1'b0, ~^8'hC3, 1'b0, 1'b0);
      check_word("ovr_held");
      check("ovr_set", 32'(bus.overrun), 32'd1);
      bus.ready = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      bus.ready = 1'b0;
      check("ovr_consume", 32'(bus.valid), 32'd0);
      check("ovr_sticky", 32'(bus.overrun), 32'd1);
      bus.clr_ovr = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      bus.clr_ovr = 1'b0;
      check("ovr_clear", 32'(bus.overrun), 32'd0);

      // Restart: partial frame then a fresh start
      bus.ready = 1'b1;
      bus.RL = 1'b0;
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b0, ~^8'h81, 1'b0, 1'b0);
      check_word("restart");
      check("restart_ovr", 32'(bus.overrun), 32'd0);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      check("restart_single", 32'(bus.valid), 32'd0);

      // Asynchronous reset mid-frame (data_out still holds 0x81)
      bus.ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0);
      repeat (4) drive(1'b1, 1'b0, 1'b1);
      #2 resetn = 1'b0;
      #1 check("async_reset",
               32'({bus.data_out, bus.valid, bus.busy, bus.overrun, bus.parity_err}), 32'd0);
      bus.EN = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      bus.ready = 1'b1;
      @(negedge clock);
      exp_q.push_back(8'hFF);
      send_frame(8'hFF, 1'b0, ~^8'hFF, 1'b0, 1'b1);
      check_word("after_reset");
      check("after_reset_perr", 32'(bus.parity_err), 32'd0);
      drive(1'b0, 1'b0, 1'b0);

`ifdef SERIAL_DESERIALIZER_PARITY_EN
      exp_q.push_back(8'h07);
      send_frame(8'h07, 1'b0, 1'b0, 1'b0, 1'b1);
      check_word("par_good");
      check("par_good_err", 32'(bus.parity_err), 32'd0);
      drive(1'b0, 1'b0, 1'b0);
      exp_q.push_back(8'h07);
      send_frame(8'h07, 1'b0, 1'b1, 1'b0, 1'b1);
      check_word("par_bad");
      check("par_bad_err", 32'(bus.parity_err), 32'd1);
      drive(1'b0, 1'b0, 1'b0);
      check("par_err_hold", 32'(bus.parity_err), 32'd1);
`else
      check("parity_tied", 32'(bus.parity_err), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_deserializer.md
# serial_deserializer

Serial-to-parallel receiver that pairs with the team's shift-register transmitter. It samples a serial bit stream framed by a `start` marker and assembles `n` bits into a parallel word. Bit order is selectable: MSB-first or LSB-first. Completed words are presented on a valid/ready output port with overrun detection. It sits on the receive side of any link driven by the transmitter's serial output.

## Interface
- `n`, default 8: word width in bits, must be ≥ 2.
- `clock  input  1`: bit clock; all state updates on the rising edge.
- `resetn  input  1`: asynchronous, active-low reset.
- `EN  input  1`: bit-valid; `serial` is sampled only when high.
- `RL  input  1`: bit order; 0 = MSB-first, 1 = LSB-first. Sampled only at frame start.
- `start  input  1`: frame marker; qualified by `EN`; the bit sampled with it is bit 0 of the frame.
- `serial  input  1`: serial data.
- `ready  input  1`: consumer accepts `data_out` when `valid && ready`.
- `clr_ovr  input  1`: synchronous clear of `overrun`.
- `data_out  output  n`: assembled word.
- `valid  output  1`: `data_out` holds an unconsumed word.
- `busy  output  1`: a frame is in progress.
- `overrun  output  1`: sticky; a word completed while the previous word was unconsumed.
- `parity_err  output  1`: see Configuration.

## Operation
- Separate shift register `sr[n-1:0]` and output register `data_out`, so the next frame is received while a word is held.
- FSM states: IDLE, SHIFT, PAR. PAR exists only with the parity macro.
- **IDLE**
  - On `EN && start`: latch `RL` into `dir`.
  - Shift in `serial`, set `cnt=1`, go to SHIFT.
  - `EN` without `start` is ignored.
- **SHIFT**, on `EN`:
  - `dir=0`: `sr <= {sr[n-2:0], serial}`, so the first bit ends in the MSB.
  - `dir=1`: `sr <= {serial, sr[n-1:1]}`, so the first bit ends in the LSB.
  - Increment `cnt`.
  - When the n-th bit is shifted, the word completes: go to IDLE, or to PAR if parity is enabled.
- `EN` low in SHIFT: hold all state; there is no timeout.
- `EN && start` in SHIFT or PAR: discard the partial frame and restart as in IDLE. This is not an error.
- Word completion with `valid` low, or with `valid && ready` in the same cycle:
  - `data_out <=` the completed word.
  - `valid <= 1`.
- Word completion with `valid && !ready`:
  - Keep the old `data_out`.
  - Drop the new word.
  - Set `overrun`.
- Consume: `valid && ready` without a completion clears `valid`.
- `overrun` clears only on `clr_ovr` or reset. A set and a clear in the same cycle resolve to set.
- `busy = (state != IDLE)`.

## Timing
- Reset value of every output is 0: `data_out`, `valid`, `busy`, `overrun`, `parity_err`. `sr`, `cnt` and `dir` are also 0, and state is IDLE.
- Reset is asynchronous. Asserting it mid-frame aborts the frame immediately; no partial word is ever emitted.
- Latency:
  - `data_out`/`valid` update on the same rising edge that samples the last data bit.
  - With parity, they update on the edge that samples the parity bit.
- Throughput: back-to-back frames, with `start` on the cycle after the last bit, are sustained with zero idle cycles provided `ready` is high.
- `ready` is purely combinational into the next-state logic of `valid`. There is no combinational path from `ready` to any output.
- The receiver samples on the rising edge, which is mid-bit relative to the transmitter's falling-edge shifting.

## Configuration
- Macro: `SERIAL_DESERIALIZER_PARITY_EN`.
- **Defined**
  - Each frame carries one extra odd-parity bit after the n data bits, handled in state PAR.
  - The word is written to `data_out` regardless of the parity result.
  - `parity_err` is updated at the same edge as `valid`: 1 if the XOR of the data bits and the parity bit is 0.
  - `parity_err` holds until the next completion or reset.
  - On a dropped (overrun) word, `parity_err` is not updated.
- **Not defined**
  - Frames are n bits.
  - PAR state is absent.
  - `parity_err` is tied to 0.

## Test plan
- n=8, RL=0, `ready=1`: `start` with bit 1, then bits 0,1,0,0,1,0,1 with EN continuously high.
  - Required: `data_out=0xA5`, `valid=1` after the 8th edge; `busy` high for cycles 1–7 only.
- n=8, RL=1: bits 1,0,1,0,0,1,0,1 with EN toggling 1/0 every cycle.
  - Required: `data_out=0xA5` after the 8th sampled bit; state is held on EN-low cycles.
- Overrun, `ready=0`: send 0x3C, then 0xC3.
  - Required: `data_out` stays 0x3C, `valid=1`, `overrun=1`.
  - Then `ready=1` for one cycle: `valid=0`.
  - Then `clr_ovr`: `overrun=0`.
- Restart: 4 bits of a frame, then `start` with the frame 0x81.
  - Required: exactly one word, 0x81, and `overrun=0`.
- Reset mid-frame: `resetn=0` asynchronously after 5 bits.
  - Required: all outputs 0 immediately.
  - A following full frame 0xFF yields `data_out=0xFF`.
- With `SERIAL_DESERIALIZER_PARITY_EN`:
  - 0x07 with parity bit 0 gives `parity_err=0`.
  - 0x07 with parity bit 1 gives `parity_err=1`.
  - Both set `valid`, 9 edges after `start`.
